// File: rtl/imem_loader.sv
// Byte-stream program loader: receives a framed image (2-byte big-endian
// length, payload, checksum) and writes the payload bytes in stream order
// into the instruction memory, holding the CPU via Busy until complete.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic        MemWE,
  output logic [31:0] MemAddr,
  output logic [7:0]  MemData,
  output logic        Busy,
  output logic        Done,
  output logic        LenErr,
  output logic        SumErr
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    SUM,
    DONE,
    ERR
  } state_t;

  state_t      state;
  state_t      state_n;

  logic [15:0] len;
  logic [15:0] idx;
  logic [7:0]  sum;

  logic        accept;
  logic [15:0] len_full;
  logic        len_bad;
  logic [15:0] idx_inc;
  logic [7:0]  sum_add;

  logic        start_load;
  logic        load_hi;
  logic        load_lo;
  logic        wr;
  logic        set_done;
  logic        set_lenerr;
  logic        set_sumerr;

  assign accept   = ByteValid && ByteReady;
  assign len_full = {len[15:8], ByteIn};
  assign len_bad  = (len_full == 16'd0) ||
                    ({16'd0, len_full} > MEM_DEPTH) ||
                    (len_full[1:0] != 2'b00);
  assign idx_inc  = idx + 16'd1;
  assign sum_add  = sum + ByteIn;

  // State register.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state decode, per-state strobes and the handshake outputs.
  always_comb begin
    state_n    = state;
    start_load = 1'b0;
    load_hi    = 1'b0;
    load_lo    = 1'b0;
    wr         = 1'b0;
    set_done   = 1'b0;
    set_lenerr = 1'b0;
    set_sumerr = 1'b0;
    ByteReady  = 1'b0;
    Busy       = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (Start) begin
          state_n    = LEN_HI;
          start_load = 1'b1;
        end
      end
      LEN_HI: begin
        ByteReady = 1'b1;
        Busy      = 1'b1;
        if (accept) begin
          load_hi = 1'b1;
          state_n = LEN_LO;
        end
      end
      LEN_LO: begin
        ByteReady = 1'b1;
        Busy      = 1'b1;
        if (accept) begin
          if (len_bad) begin
            state_n    = ERR;
            set_lenerr = 1'b1;
          end else begin
            state_n = DATA;
            load_lo = 1'b1;
          end
        end
      end
      DATA: begin
        ByteReady = 1'b1;
        Busy      = 1'b1;
        if (accept) begin
          wr = 1'b1;
          if (idx_inc == len) begin
            state_n = SUM;
          end
        end
      end
      SUM: begin
        ByteReady = 1'b1;
        Busy      = 1'b1;
        if (accept) begin
          if (sum_add == 8'd0) begin
            state_n  = DONE;
            set_done = 1'b1;
          end else begin
            state_n    = ERR;
            set_sumerr = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Length capture, payload index and running checksum.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      len <= '0;
      idx <= '0;
      sum <= '0;
    end else begin
      if (start_load) begin
        idx <= '0;
        sum <= '0;
      end
      if (load_hi) begin
        len[15:8] <= ByteIn;
      end
      if (load_lo) begin
        len[7:0] <= ByteIn;
        idx      <= '0;
      end
      if (wr) begin
        idx <= idx_inc;
        sum <= sum_add;
      end
    end
  end

  // Registered memory write port; address/data hold between strobes.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      MemWE   <= 1'b0;
      MemAddr <= '0;
      MemData <= '0;
    end else begin
      MemWE <= wr;
      if (wr) begin
        MemAddr <= BASE_ADDR + {16'd0, idx};
        MemData <= ByteIn;
      end
    end
  end

  // Sticky completion and error flags, cleared only by a new Start.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      Done   <= 1'b0;
      LenErr <= 1'b0;
      SumErr <= 1'b0;
    end else begin
      if (start_load) begin
        Done   <= 1'b0;
        LenErr <= 1'b0;
        SumErr <= 1'b0;
      end
      if (set_done) begin
        Done <= 1'b1;
      end
      if (set_lenerr) begin
        LenErr <= 1'b1;
      end
      if (set_sumerr) begin
        SumErr <= 1'b1;
      end
    end
  end

endmodule
